// File: rtl/mips_program_checker_if.sv
// mips_program_checker_if
//   Bundle of the load port, run control, CPU fetch/store buses and verdict
//   outputs of mips_program_checker.
//   master : the bench / board side (drives loads, start, CPU buses)
//   slave  : the checker (serves imemrd, drives cpu_reset and the verdict)
//   Widths follow the checker parameters; IW = index width, CW = cycle
//   counter width.
interface mips_program_checker_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int INST_BUS_WIDTH = 17,
  parameter int DATA_BUS_WIDTH = 17,
  parameter int PROG_DEPTH     = 64,
  parameter int TRACE_DEPTH    = 16,
  parameter int TIMEOUT        = 1024
) ();
  localparam int MAX_DEPTH = (PROG_DEPTH > TRACE_DEPTH) ? PROG_DEPTH : TRACE_DEPTH;
  localparam int IW        = $clog2(MAX_DEPTH);
  localparam int CW        = $clog2(TIMEOUT + 1);

  logic                      ld_valid;
  logic                      ld_sel;
  logic [IW-1:0]             ld_idx;
  logic [DATA_BUS_WIDTH-1:0] ld_adr;
  logic [DATA_WIDTH-1:0]     ld_data;
  logic                      start;
  logic [INST_BUS_WIDTH-1:0] iadr;
  logic [DATA_WIDTH-1:0]     imemrd;
  logic                      dmemwrite;
  logic [DATA_BUS_WIDTH-1:0] dadr;
  logic [DATA_WIDTH-1:0]     dmemwd;
  logic                      cpu_reset;
  logic                      done;
  logic                      pass;
  logic                      timed_out;
  logic [7:0]                err_count;
  logic [IW-1:0]             first_err_idx;
  logic [CW-1:0]             cycles;

  modport master (
    output ld_valid, ld_sel, ld_idx, ld_adr, ld_data, start,
           iadr, dmemwrite, dadr, dmemwd,
    input  imemrd, cpu_reset, done, pass, timed_out,
           err_count, first_err_idx, cycles
  );

  modport slave (
    input  ld_valid, ld_sel, ld_idx, ld_adr, ld_data, start,
           iadr, dmemwrite, dadr, dmemwd,
    output imemrd, cpu_reset, done, pass, timed_out,
           err_count, first_err_idx, cycles
  );
endinterface

// File: rtl/mips_program_checker.sv
// mips_program_checker
//   Program feed and store-trace checker for the mips pipeline. In IDLE the
//   instruction store and expected store trace are loaded; start releases
//   the CPU from reset, serves instructions from iadr and compares every
//   data-memory write against the trace until the trace is exhausted
//   (pass/fail) or the cycle budget runs out (timed_out).
//   Ports:
//     clk   : single clock
//     reset : synchronous, active-high; forces IDLE from any state
//     bus   : mips_program_checker_if.slave (load port, start, iadr/imemrd,
//             dmemwrite/dadr/dmemwd, cpu_reset, done, pass, timed_out,
//             err_count, first_err_idx, cycles)
//   Optional feature: define PROG_OOR_TRAP_EN to end a run with a failure
//   when the CPU fetches beyond the loaded program.
module mips_program_checker #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    INST_BUS_WIDTH = 17,
  parameter int                    DATA_BUS_WIDTH = 17,
  parameter int                    PROG_DEPTH     = 64,
  parameter int                    TRACE_DEPTH    = 16,
  parameter int                    TIMEOUT        = 1024,
  parameter logic [DATA_WIDTH-1:0] NOP_WORD       = 32'h2000_0000
) (
  input logic                    clk,
  input logic                    reset,
  mips_program_checker_if.slave  bus
);
  localparam int MAX_DEPTH = (PROG_DEPTH > TRACE_DEPTH) ? PROG_DEPTH : TRACE_DEPTH;
  localparam int IW        = $clog2(MAX_DEPTH);
  localparam int LW        = IW + 1;  // lengths run up to the full depth
  localparam int CW        = $clog2(TIMEOUT + 1);
  localparam int PW        = (PROG_DEPTH > 1) ? $clog2(PROG_DEPTH) : 1;
  localparam int TW        = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int WW        = INST_BUS_WIDTH - 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [DATA_WIDTH-1:0]     prog       [PROG_DEPTH];
  logic [DATA_BUS_WIDTH-1:0] trace_adr  [TRACE_DEPTH];
  logic [DATA_WIDTH-1:0]     trace_data [TRACE_DEPTH];

  logic [1:0]    state;
  logic [LW-1:0] prog_len, trace_len, ptr;
  logic [CW-1:0] cycles;
  logic [7:0]    err_count;
  logic [IW-1:0] first_err_idx;
  logic          done_q, pass_q, timed_out_q, cpu_reset_q;

  // Load decode: out-of-depth indices are dropped entirely.
  logic prog_ld, trace_ld;
  assign prog_ld  = bus.ld_valid && !bus.ld_sel && (int'(bus.ld_idx) < PROG_DEPTH);
  assign trace_ld = bus.ld_valid &&  bus.ld_sel && (int'(bus.ld_idx) < TRACE_DEPTH);

  // Fetch: byte address to word index, low two bits ignored.
  logic [WW-1:0] w;
  logic          w_in_prog;
  assign w         = bus.iadr[INST_BUS_WIDTH-1:2];
  assign w_in_prog = 32'(w) < 32'(prog_len);
  assign bus.imemrd = (state == S_RUN && w_in_prog) ? prog[w[PW-1:0]] : NOP_WORD;

  // Store check against the current trace entry; stores past the end of the
  // trace are not compared.
  logic          store_live, mismatch, complete, hit_timeout, trap;
  logic [LW-1:0] ptr_next;
  logic [7:0]    err_next;
  logic [TW-1:0] pi;
  assign pi          = ptr[TW-1:0];
  assign store_live  = bus.dmemwrite && (ptr < trace_len);
  assign mismatch    = store_live &&
                       ((trace_adr[pi] != bus.dadr) || (trace_data[pi] != bus.dmemwd));
  assign ptr_next    = store_live ? ptr + LW'(1) : ptr;
  assign err_next    = (mismatch && err_count != 8'hff) ? err_count + 8'd1 : err_count;
  assign complete    = (ptr_next == trace_len);
  assign hit_timeout = (cycles == CW'(TIMEOUT - 1));
`ifdef PROG_OOR_TRAP_EN
  assign trap        = !w_in_prog;
`else
  assign trap        = 1'b0;
`endif

  // NOTE: the arrays carry no reset; only entries below prog_len/trace_len
  // are ever read, and those lengths do reset.
  always_ff @(posedge clk) begin
    if (!reset && state == S_IDLE) begin
      if (prog_ld) prog[bus.ld_idx[PW-1:0]] <= bus.ld_data;
      if (trace_ld) begin
        trace_adr[bus.ld_idx[TW-1:0]]  <= bus.ld_adr;
        trace_data[bus.ld_idx[TW-1:0]] <= bus.ld_data;
      end
    end
  end

  // NOTE: all state registers use non-blocking assignments so every branch
  // reads the pre-edge values of ptr, err_count and cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      prog_len      <= '0;
      trace_len     <= '0;
      ptr           <= '0;
      cycles        <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timed_out_q   <= 1'b0;
      cpu_reset_q   <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.ld_valid) begin
            // A load in the same cycle as start wins; the start is dropped.
            if (prog_ld)  prog_len  <= LW'(bus.ld_idx) + LW'(1);
            if (trace_ld) trace_len <= LW'(bus.ld_idx) + LW'(1);
          end else if (bus.start) begin
            state       <= S_RUN;
            ptr         <= '0;
            cycles      <= '0;
            err_count   <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timed_out_q <= 1'b0;
            cpu_reset_q <= 1'b0;
          end
        end
        S_RUN: begin
          ptr       <= ptr_next;
          err_count <= err_next;
          cycles    <= cycles + CW'(1);
          if (mismatch && err_count == 8'd0) first_err_idx <= ptr[IW-1:0];
          // Exit priority: fetch trap, then trace completion, then timeout.
          if (trap || complete || hit_timeout) begin
            state       <= S_DONE;
            done_q      <= 1'b1;
            cpu_reset_q <= 1'b1;
            if (trap)          pass_q      <= 1'b0;
            else if (complete) pass_q      <= (err_next == 8'd0);
            else               timed_out_q <= 1'b1;
          end
        end
        default: ;  // DONE holds until reset
      endcase
    end
  end

  assign bus.cpu_reset     = cpu_reset_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.timed_out     = timed_out_q;
  assign bus.err_count     = err_count;
  assign bus.first_err_idx = first_err_idx;
  assign bus.cycles        = cycles;
endmodule

// File: doc/mips_program_checker.md
# mips_program_checker

Parametrised, synthesisable program-feed and store-trace checker for the `mips` pipeline. It replaces hand-driven per-cycle `imemrd` stimulus with a loadable instruction store served from `iadr`. It also checks every data-memory write against a loaded expected trace. A run ends in a pass/fail/timeout verdict. It sits beside `mips` and `dataram` in the bench and on FPGA bring-up boards. It drives `imemrd` and the CPU's reset, and snoops the data bus.

## Interface
- `DATA_WIDTH`, 32, instruction/data word width
- `INST_BUS_WIDTH`, 17, byte-address width of `iadr`
- `DATA_BUS_WIDTH`, 17, width of `dadr`
- `PROG_DEPTH`, 64, instruction words held
- `TRACE_DEPTH`, 16, expected store entries held
- `TIMEOUT`, 1024, maximum RUN cycles
- `NOP_WORD`, 32'h20000000, word returned outside the program
- Index width: IW = $clog2(max(PROG_DEPTH, TRACE_DEPTH)). Counter width: CW = $clog2(TIMEOUT+1).

Ports:
- `clk`  in  1  clock; one clock domain
- `reset`  in  1  reset, synchronous, active-high
- `ld_valid`  in  1  load strobe; accepted in IDLE only
- `ld_sel`  in  1  0 = program word, 1 = trace entry
- `ld_idx`  in  IW  word/entry index
- `ld_adr`  in  DATA_BUS_WIDTH  expected store address (trace only)
- `ld_data`  in  DATA_WIDTH  instruction or expected store data
- `start`  in  1  begin run; accepted in IDLE only
- `iadr`  in  INST_BUS_WIDTH  CPU fetch byte address
- `imemrd`  out  DATA_WIDTH  instruction to CPU
- `dmemwrite`  in  1  CPU store strobe
- `dadr`  in  DATA_BUS_WIDTH  CPU data address
- `dmemwd`  in  DATA_WIDTH  CPU store data
- `cpu_reset`  out  1  reset to `mips`
- `done`  out  1  verdict valid
- `pass`  out  1  run passed
- `timed_out`  out  1  TIMEOUT reached
- `err_count`  out  8  mismatching stores, saturating at 255
- `first_err_idx`  out  IW  trace index of the first mismatch
- `cycles`  out  CW  RUN cycles elapsed

## Operation
- States: IDLE, RUN, DONE. `reset` forces IDLE from any state, including mid-run.
- Reset values:
  - `cpu_reset`=1; `done`, `pass`, `timed_out`=0
  - `err_count`, `first_err_idx`, `cycles`=0
  - `prog_len`, `trace_len`, trace pointer `ptr`=0
  - Array contents are not cleared.
- IDLE, loading:
  - `ld_valid` with `ld_sel`=0 writes `prog[ld_idx]` and sets `prog_len` = `ld_idx`+1.
  - `ld_valid` with `ld_sel`=1 writes `trace[ld_idx]`={`ld_adr`,`ld_data`} and sets `trace_len` = `ld_idx`+1.
  - Entries are loaded in ascending order. An `ld_idx` at or beyond the respective depth is ignored.
- IDLE, start:
  - `start` enters RUN and clears `ptr`, `cycles`, `err_count`, `done`, `pass`, `timed_out`.
  - If `ld_valid` and `start` are both asserted, the load happens and the start is ignored.
- Fetch, combinational:
  - Word index w = `iadr`[INST_BUS_WIDTH-1:2]. `iadr`[1:0] is ignored.
  - `imemrd` = `prog[w]` if w < `prog_len`, else `NOP_WORD`.
  - Outside RUN, `imemrd` = `NOP_WORD`.
- RUN:
  - `cpu_reset`=0. `cycles` increments every cycle.
  - On each `dmemwrite`=1 cycle, {`dadr`,`dmemwd`} is compared with `trace[ptr]`, then `ptr` increments.
  - On mismatch, `err_count` increments (saturating). The first mismatch latches `first_err_idx`=`ptr`.
- Leaving RUN:
  - When `ptr` reaches `trace_len`, the block enters DONE and `pass` = (`err_count`==0), including the final compare.
  - When `cycles` reaches TIMEOUT-1 without completion, the block enters DONE with `timed_out`=1 and `pass`=0.
  - If the last expected store and the timeout fall in the same cycle, completion wins and `timed_out`=0.
  - `start` with `trace_len`=0 enters RUN and goes to DONE next cycle with `pass`=1.
- DONE:
  - `done`=1 and `cpu_reset`=1; the CPU is halted. Further stores are ignored.
  - Only `reset` leaves DONE. `start` in DONE is ignored.

## Timing
- `imemrd` has zero latency from `iadr`. The CPU samples it at the next `clk` edge.
- Compare results (`err_count`, `first_err_idx`, `ptr`) update on the edge ending the store cycle.
- `done` and `pass` are registered and rise on the edge after the final store cycle.
- `cpu_reset` falls on the edge that enters RUN, so the CPU fetches `iadr`=0 in the first RUN cycle.
- Load-to-fetch: a program word loaded on edge k is visible from cycle k+1.

## Configuration
- Macro: `PROG_OOR_TRAP_EN`.
- Defined: in RUN, a fetch with w ≥ `prog_len` ends the run.
  - The block enters DONE next edge with `pass`=0.
  - The trap takes priority over completion in the same cycle.
  - `imemrd`=`NOP_WORD` during that cycle.
- Undefined: out-of-range fetches return `NOP_WORD` silently, as described above.

## Test plan
- Load program {20010000, 08000005, 2021000a×3, 2002000a, 2042000a}, trace empty, `start` -> `imemrd`=08000005 when `iadr`=4; `imemrd`=20000000 when `iadr`=0x40; next cycle `done`=1, `pass`=1.
- Trace {(0xff, 0x14)}; CPU store dadr=0xff, dmemwd=0x14 -> `err_count`=0; `done`=1 and `pass`=1 one edge later.
- Trace {(0xff,0x14), (0x0a,0)}; stores (0xff,0x14), (0x0a,5) -> `err_count`=1, `first_err_idx`=1, `pass`=0.
- TIMEOUT=8, trace of 1 entry, no store -> `done`=1, `timed_out`=1 after 8 RUN cycles; `cpu_reset`=1.
- `reset` asserted during RUN at `cycles`=3 -> next edge: IDLE, all outputs at reset values, `cpu_reset`=1; a following `start` reruns from `iadr`=0.
- `PROG_OOR_TRAP_EN` defined, `prog_len`=2, CPU fetches `iadr`=8 -> `done`=1, `pass`=0 next edge.
